// File: rtl/vga_timing_gen.sv
// Purpose: 640x480@60 VGA raster timing: h/v counters plus registered, mutually aligned sync/blank/strobe decode.
// Latency: outputs are decoded from next-state counters, so every output describes the same (x,y) in the same cycle.
// Backpressure: none; free-running, never stalls. Optional frame_count port under `ifdef VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic       line_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
  output logic       frame_start,
  output logic [9:0] frame_count
`else
  output logic       frame_start
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] h_nxt;
  logic [9:0] v_nxt;

  // Next raster position: h wraps every line, v advances only on the h wrap.
  always_comb begin
    h_nxt = x + 10'd1;
    v_nxt = y;
    if (x == H_LAST) begin
      h_nxt = '0;
      if (y == V_LAST) begin
        v_nxt = '0;
      end else begin
        v_nxt = y + 10'd1;
      end
    end
  end

  // Counters and all decoded outputs register together from the next-state position, so they never skew.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x           <= '0;
      y           <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      display_on  <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      x           <= h_nxt;
      y           <= v_nxt;
      hsync       <= !((h_nxt >= H_SYNC_BEG) && (h_nxt < H_SYNC_END));
      vsync       <= !((v_nxt >= V_SYNC_BEG) && (v_nxt < V_SYNC_END));
      display_on  <= (h_nxt < H_ACT_END) && (v_nxt < V_ACT_END);
      line_start  <= (h_nxt == 10'd0);
      frame_start <= (h_nxt == 10'd0) && (v_nxt == 10'd0);
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  // Frame counter advances the cycle after each frame_start pulse and wraps naturally at 1023.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count <= '0;
    end else begin
      frame_count <= frame_count + {9'd0, frame_start};
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a scaled-down raster (30x15 totals) for whole-frame behaviour, plus a
// default-parameter instance for the real 640x480 horizontal timing on the first line.
// Scaled timing: h active 0..19, hsync low 22..26, total 30; v active 0..7, vsync low 10..11, total 15.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [9:0] sx, sy, fx, fy;
  logic shs, svs, sde, sls, sfs;
  logic fhs, fvs, fde, fls, ffs;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [9:0] sfc, ffc;
`endif

  vga_timing_gen #(
    .H_ACTIVE(20), .H_FP(2), .H_SYNC(5), .H_BP(3),
    .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x(sx), .y(sy), .hsync(shs), .vsync(svs),
    .display_on(sde), .line_start(sls),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_start(sfs), .frame_count(sfc)
`else
    .frame_start(sfs)
`endif
  );

  vga_timing_gen dut_full (
    .clk(clk), .rst_n(rst_n), .x(fx), .y(fy), .hsync(fhs), .vsync(fvs),
    .display_on(fde), .line_start(fls),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_start(ffs), .frame_count(ffc)
`else
    .frame_start(ffs)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    int cyc;
    int eh, ev;
    int xy_err, hs_err, vs_err, de_err, ls_err, fs_err;
    int de_cnt, vs_low, rise_cnt, rise1, rise2, fs_cnt, fs1, fs2, ymax;
    int f_hs_low, f_hs_first, f_hs_last, f_de_fall, f_ls_cnt, f_ls_x;
    logic prev_vs;
    logic hs_e, vs_e, de_e, ls_e, fs_e;
    bit found;

    xy_err = 0; hs_err = 0; vs_err = 0; de_err = 0; ls_err = 0; fs_err = 0;
    de_cnt = 0; vs_low = 0; rise_cnt = 0; rise1 = -1; rise2 = -1;
    fs_cnt = 0; fs1 = -1; fs2 = -1; ymax = 0;
    f_hs_low = 0; f_hs_first = -1; f_hs_last = -1; f_de_fall = -1; f_ls_cnt = 0; f_ls_x = -1;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_x", sx, 0);
    chk("rst_y", sy, 0);
    chk("rst_hsync", shs, 1);
    chk("rst_vsync", svs, 1);
    chk("rst_display_on", sde, 1);
    chk("rst_line_start", sls, 0);
    chk("rst_frame_start", sfs, 0);
    chk("rst_full_hsync", fhs, 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("rst_frame_count", sfc, 0);
`endif

    // Release between edges; cycle 0 is the reset-state cycle
    rst_n = 1'b1;
    #1;
    chk("c0_x", sx, 0);
    chk("c0_frame_start", sfs, 0);
    chk("c0_line_start", sls, 0);
    @(negedge clk);
    chk("c1_x", sx, 1);
    chk("c1_y", sy, 0);
    chk("c1_frame_start", sfs, 0);
    @(negedge clk);
    chk("c2_x", sx, 2);
    chk("c2_y", sy, 0);
    chk("c2_frame_start", sfs, 0);
    chk("c2_hsync", shs, 1);
    chk("c2_vsync", svs, 1);
    chk("c2_display_on", sde, 1);
    cyc = 2;
    prev_vs = svs;

    // Two full scaled frames, with the default instance's first line watched alongside
    while (cyc < 905) begin
      @(negedge clk);
      cyc++;
      eh = cyc % 30;
      ev = (cyc / 30) % 15;
      hs_e = !(eh >= 22 && eh < 27);
      vs_e = !(ev >= 10 && ev < 12);
      de_e = (eh < 20) && (ev < 8);
      ls_e = (eh == 0);
      fs_e = (eh == 0) && (ev == 0);
      if (sx !== 10'(eh) || sy !== 10'(ev)) xy_err++;
      if (shs !== hs_e) hs_err++;
      if (svs !== vs_e) vs_err++;
      if (sde !== de_e) de_err++;
      if (sls !== ls_e) ls_err++;
      if (sfs !== fs_e) fs_err++;
      if (cyc >= 450 && cyc < 900) begin
        if (sde) de_cnt++;
        if (!svs) vs_low++;
      end
      if (svs && !prev_vs) begin
        rise_cnt++;
        if (rise1 < 0) rise1 = cyc; else if (rise2 < 0) rise2 = cyc;
      end
      prev_vs = svs;
      if (sfs) begin
        fs_cnt++;
        if (fs1 < 0) fs1 = cyc; else if (fs2 < 0) fs2 = cyc;
      end
      if (int'(sy) > ymax) ymax = int'(sy);

      if (cyc <= 800) begin
        if (!fhs) begin
          f_hs_low++;
          if (f_hs_first < 0) f_hs_first = int'(fx);
          f_hs_last = int'(fx);
        end
        if (!fde && f_de_fall < 0) f_de_fall = int'(fx);
        if (fls) begin
          f_ls_cnt++;
          f_ls_x = int'(fx);
        end
      end
      if (cyc == 799) begin
        chk("full_x_last", fx, 799);
        chk("full_y_last", fy, 0);
      end
      if (cyc == 800) begin
        chk("full_x_wrap", fx, 0);
        chk("full_y_inc", fy, 1);
      end
    end

    chk("xy_track_errs", xy_err, 0);
    chk("hsync_errs", hs_err, 0);
    chk("vsync_errs", vs_err, 0);
    chk("display_on_errs", de_err, 0);
    chk("line_start_errs", ls_err, 0);
    chk("frame_start_errs", fs_err, 0);
    chk("display_on_per_frame", de_cnt, 160);
    chk("vsync_low_per_frame", vs_low, 60);
    chk("vsync_rise_count", rise_cnt, 2);
    chk("vsync_rise_first", rise1, 360);
    chk("vsync_rise_period", rise2 - rise1, 450);
    chk("frame_start_count", fs_cnt, 2);
    chk("frame_start_first", fs1, 450);
    chk("frame_start_period", fs2 - fs1, 450);
    chk("y_max", ymax, 14);
    chk("full_hsync_low_cycles", f_hs_low, 96);
    chk("full_hsync_first_x", f_hs_first, 656);
    chk("full_hsync_last_x", f_hs_last, 751);
    chk("full_display_fall_x", f_de_fall, 640);
    chk("full_line_start_count", f_ls_cnt, 1);
    chk("full_line_start_x", f_ls_x, 0);

    // Mid-frame asynchronous reset while both sync pulses are low
    found = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (sx == 10'd24 && sy == 10'd11) found = 1;
    end
    chk("reach_reset_point", found, 1);
    chk("pre_reset_hsync", shs, 0);
    chk("pre_reset_vsync", svs, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_x", sx, 0);
    chk("async_rst_y", sy, 0);
    chk("async_rst_hsync", shs, 1);
    chk("async_rst_vsync", svs, 1);
    chk("async_rst_full_x", fx, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("fc_after_reset", sfc, 0);
`endif

    // Next frame_start after release
    cyc = 0;
    found = 0;
    while (!found && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (sfs) found = 1;
    end
    chk("frame_start_found", found, 1);
    chk("frame_start_after_release", cyc, 450);

`ifdef VGA_TIMING_FRAME_CNT_EN
    @(negedge clk);
    chk("fc_one", sfc, 1);
    for (int k = 2; k <= 3; k++) begin
      found = 0;
      for (int i = 0; i < 1000 && !found; i++) begin
        @(negedge clk);
        if (sfs) found = 1;
      end
      chk("fc_fs_found", found, 1);
      @(negedge clk);
      chk("fc_count", sfc, k);
    end
    force dut.frame_count = 10'd1023;
    #1;
    release dut.frame_count;
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (sfs) found = 1;
    end
    chk("fc_wrap_fs_found", found, 1);
    chk("fc_pre_wrap", sfc, 1023);
    @(negedge clk);
    chk("fc_wrap", sfc, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing from a single 25.175 MHz (nominal 25 MHz) pixel clock.
- Sits directly upstream of the pattern stage: supplies pixel coordinates `x`/`y` and `vsync` to it, and `hsync`/`display_on` to the top-level output mux.
- Free-running horizontal/vertical counters with registered, mutually aligned sync and blanking decode, plus frame/line start strobes.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- x  out  10  horizontal counter h, 0..H_TOTAL-1
- y  out  10  vertical counter v, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- display_on  out  1  high when h<H_ACTIVE and v<V_ACTIVE
- line_start  out  1  one-cycle pulse when h==0
- frame_start  out  1  one-cycle pulse when h==0 and v==0

Behaviour:
- Clock and reset: one clock (`clk`); reset (`rst_n`) is asynchronous and active-low.
- Derived constants: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (525). Counter widths are fixed at 10 bits; the defaults fit.
- Reset (rst_n low, asynchronous), all held until release: h=0, v=0, hsync=1, vsync=1, display_on=1, line_start=0, frame_start=0.
- First rising clk edge after release: h=1, v=0. The raster restarts cleanly from the origin.
- Horizontal counter: increments by 1 every cycle; at H_TOTAL-1 it wraps to 0.
- Vertical counter: increments only on the cycle h wraps; at V_TOTAL-1 (together with the h wrap) it wraps to 0.
- All outputs are registers. Each is decoded from the next-state counter values, so every output describes the same (h,v) as `x`/`y` on the same cycle, with zero skew between them.
- hsync=0 iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751).
- vsync=0 iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491), for whole lines. Edges coincide with h==0.
- vsync rising edge: occurs at (h=0, v=492), once per frame. Downstream frame counting relies on exactly one rising edge per frame.
- line_start: high for exactly the cycle where x==0. frame_start: high for exactly the cycle where x==0 and y==0.
- Reset strobe rule: neither strobe is asserted while in reset or on the reset-state cycle. The first frame_start occurs on the first wrap to (0,0), i.e. H_TOTAL*V_TOTAL cycles after release.
- display_on drops at h==H_ACTIVE and at v==V_ACTIVE. It is never high outside the 640x480 window.
- Reset mid-frame: counters and outputs return to reset values immediately (asynchronously). No partial sync pulse is extended; hsync/vsync go high at once.
- No other inputs; the block never stalls.

Optional Feature:
- Macro VGA_TIMING_FRAME_CNT_EN.
- Defined: adds output port `frame_count`  out  10. It resets to 0, increments by 1 on each cycle frame_start is high, and wraps 1023->0. It lets the pattern stage and debug logic time-stamp frames without their own vsync edge detector.
- Undefined: the port and its register are absent. All other behaviour is identical.

Test Plan:
- Reset then release; sample for 3 cycles -> (x,y)=(0,0),(1,0),(2,0); hsync=vsync=1; display_on=1; frame_start=0 on all three.
- Run one line from release -> hsync low exactly at x=656..751 (96 cycles); display_on falls at x=640; x wraps 799->0 and y increments to 1 on the same cycle; line_start high only at x=0.
- Run two full frames -> vsync low for exactly 1600 cycles (lines 490-491); successive vsync rising edges and successive frame_start pulses each 420000 cycles apart; y never exceeds 524.
- Assert rst_n low at (x=700,y=491), asynchronously between clock edges -> hsync, vsync and counters reset without waiting for clk; after release the next frame_start arrives 420000 cycles later.
- Check display_on over a whole frame -> exactly 307200 high cycles per 420000.
- With VGA_TIMING_FRAME_CNT_EN defined, run 3 frames -> frame_count reads 0, then 1, 2, 3 after each frame_start. Force the counter to 1023 and hit the next frame_start -> it wraps to 0.
